// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/flow-control FSM driving program_counter strobes with a return-address stack
// Ports: clk, rst_n (async active-low); restart (sync soft restart); mem_ready, pc_in (fetch handshake);
//   op_jump/op_call/op_ret/op_branch/branch_taken/op_halt, jump_addr, branch_addr, irq (decode/interrupt);
//   fetch_req, pc_clear/pc_up/pc_load1/pc_in1/pc_load2/pc_in2/pc_dbus_en/pc_dbus (PC control);
//   irq_ack, halted, stack_err (status).
module pc_sequencer #(
   parameter int ADDR_W = 8,
   parameter int STACK_DEPTH = 4,
   parameter logic [ADDR_W-1:0] IRQ_VECTOR = 8'hF0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              restart,
   input  logic              mem_ready,
   input  logic [ADDR_W-1:0] pc_in,
   input  logic              op_jump,
   input  logic              op_call,
   input  logic              op_ret,
   input  logic              op_branch,
   input  logic              branch_taken,
   input  logic              op_halt,
   input  logic [ADDR_W-1:0] jump_addr,
   input  logic [ADDR_W-1:0] branch_addr,
   input  logic              irq,
   output logic              fetch_req,
   output logic              pc_clear,
   output logic              pc_up,
   output logic              pc_load1,
   output logic [ADDR_W-1:0] pc_in1,
   output logic              pc_load2,
   output logic [ADDR_W-1:0] pc_in2,
   output logic              pc_dbus_en,
   output logic [ADDR_W-1:0] pc_dbus,
   output logic              irq_ack,
   output logic              halted,
   output logic              stack_err
);
   localparam int CW = $clog2(STACK_DEPTH + 1);
   localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   typedef enum logic [1:0] {CLEAR, FETCH, EXEC, HALT} state_t;
   state_t state, state_nx;
   logic [ADDR_W-1:0] stk [STACK_DEPTH];
   logic [CW-1:0] cnt;
   logic push, pop, full, empty;
   logic [ADDR_W-1:0] ret_addr, top;
   assign full = cnt == CW'(STACK_DEPTH);
   assign empty = cnt == '0;
   assign ret_addr = pc_in + ADDR_W'(1);
   // guarded so an empty stack never reads an out-of-range entry
   assign top = empty ? '0 : stk[IW'(cnt - CW'(1))];
   assign pc_in1 = jump_addr;
   assign pc_in2 = branch_addr;
   assign halted = state == HALT;
   always_comb begin
      state_nx = state;
      fetch_req = 1'b0;
      pc_clear = 1'b0;
      pc_up = 1'b0;
      pc_load1 = 1'b0;
      pc_load2 = 1'b0;
      pc_dbus_en = 1'b0;
      pc_dbus = '0;
      irq_ack = 1'b0;
      push = 1'b0;
      pop = 1'b0;
      if (restart) begin
         state_nx = CLEAR;
         pc_clear = state == CLEAR;
      end else begin
         case (state)
            CLEAR: begin
               pc_clear = 1'b1;
               state_nx = FETCH;
            end
            FETCH: begin
               fetch_req = 1'b1;
               state_nx = mem_ready ? EXEC : FETCH;
            end
            EXEC: begin
               state_nx = FETCH;
               if (irq) begin
                  push = 1'b1;
                  pc_dbus_en = 1'b1;
                  pc_dbus = IRQ_VECTOR;
                  irq_ack = 1'b1;
               end else if (op_halt) begin
                  state_nx = HALT;
               end else if (op_ret) begin
                  // popping an empty stack degrades to a plain increment
                  pop = 1'b1;
                  pc_up = empty;
                  pc_dbus_en = !empty;
                  pc_dbus = top;
               end else if (op_call) begin
                  push = 1'b1;
                  pc_load1 = 1'b1;
               end else if (op_jump) begin
                  pc_load1 = 1'b1;
               end else if (op_branch && branch_taken) begin
                  pc_load2 = 1'b1;
               end else begin
                  pc_up = 1'b1;
               end
            end
            default: begin
               if (irq) begin
                  push = 1'b1;
                  pc_dbus_en = 1'b1;
                  pc_dbus = IRQ_VECTOR;
                  irq_ack = 1'b1;
                  state_nx = FETCH;
               end
            end
         endcase
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= CLEAR;
         cnt <= '0;
         stack_err <= 1'b0;
         for (int i = 0; i < STACK_DEPTH; i++) stk[i] <= '0;
      end else begin
         state <= state_nx;
         if (restart) begin
            cnt <= '0;
            stack_err <= 1'b0;
         end else if (push) begin
            if (full) stack_err <= 1'b1;
            else begin
               stk[IW'(cnt)] <= ret_addr;
               cnt <= cnt + CW'(1);
            end
         end else if (pop) begin
            if (empty) stack_err <= 1'b1;
            else cnt <= cnt - CW'(1);
         end
      end
   end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed self-checking bench for pc_sequencer with a behavioural program counter
module tb_pc_sequencer;
   logic clk = 1'b0, rst_n = 1'b0, restart = 1'b0, mem_ready = 1'b1;
   logic op_jump = 1'b0, op_call = 1'b0, op_ret = 1'b0, op_branch = 1'b0, branch_taken = 1'b0, op_halt = 1'b0, irq = 1'b0;
   logic [7:0] jump_addr = '0, branch_addr = '0, pc;
   logic fetch_req, pc_clear, pc_up, pc_load1, pc_load2, pc_dbus_en, irq_ack, halted, stack_err;
   logic [7:0] pc_in1, pc_in2, pc_dbus;
   logic [4:0] stb;
   int checks = 0, failures = 0;
   logic [7:0] ret_exp [4] = '{8'h81, 8'h71, 8'h61, 8'h01};
   logic [7:0] call_pc [5] = '{8'h00, 8'h60, 8'h70, 8'h80, 8'h90};
   always #5 clk = ~clk;
   pc_sequencer dut (
      .clk(clk), .rst_n(rst_n), .restart(restart), .mem_ready(mem_ready), .pc_in(pc),
      .op_jump(op_jump), .op_call(op_call), .op_ret(op_ret), .op_branch(op_branch),
      .branch_taken(branch_taken), .op_halt(op_halt), .jump_addr(jump_addr),
      .branch_addr(branch_addr), .irq(irq), .fetch_req(fetch_req), .pc_clear(pc_clear),
      .pc_up(pc_up), .pc_load1(pc_load1), .pc_in1(pc_in1), .pc_load2(pc_load2),
      .pc_in2(pc_in2), .pc_dbus_en(pc_dbus_en), .pc_dbus(pc_dbus), .irq_ack(irq_ack),
      .halted(halted), .stack_err(stack_err)
   );
   assign stb = {pc_clear, pc_up, pc_load1, pc_load2, pc_dbus_en};
   always @(posedge clk or negedge rst_n)
      if (!rst_n) pc <= '0;
      else if (pc_clear) pc <= '0;
      else if (pc_up) pc <= pc + 8'd1;
      else if (pc_load1) pc <= pc_in1;
      else if (pc_load2) pc <= pc_in2;
      else if (pc_dbus_en) pc <= pc_dbus;
   always @(negedge clk) begin
      checks++;
      if ($countones(stb) > 1) begin
         failures++;
         $display("FAIL onehot strobes=%b required at most one set", stb);
      end
   end
   task automatic clear_ops();
      @(posedge clk);
      #1;
      {op_jump, op_call, op_ret, op_branch, branch_taken, op_halt, irq, restart} = '0;
   endtask
   task automatic to_exec();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(fetch_req === 1'b0 && pc_clear === 1'b0 && halted === 1'b0) && n < 20);
      checks++;
      if (n >= 20) begin
         failures++;
         $display("FAIL exec_timeout cycles=%0d required <20", n);
      end
   endtask
   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++;
      if ({stb, fetch_req, irq_ack, halted, stack_err, pc_dbus} !== {5'b10000, 4'b0, 8'h00}) begin
         failures++;
         $display("FAIL reset_outputs got=%b/%b%b%b%b/%h required=10000/0000/00", stb, fetch_req, irq_ack, halted, stack_err, pc_dbus);
      end
      rst_n = 1'b1;
      #1;
      checks++;
      if (stb !== 5'b10000) begin
         failures++;
         $display("FAIL clear_after_release got=%b required=10000", stb);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (fetch_req !== 1'b1 || stb !== 5'b00000 || pc !== 8'(i)) begin
            failures++;
            $display("FAIL seq_fetch%0d req=%b strobes=%b pc=%h required req=1 strobes=00000 pc=%h", i, fetch_req, stb, pc, 8'(i));
         end
         @(negedge clk);
         checks++;
         if (fetch_req !== 1'b0 || stb !== 5'b01000) begin
            failures++;
            $display("FAIL seq_exec%0d req=%b strobes=%b required req=0 strobes=01000", i, fetch_req, stb);
         end
      end
   endtask
   task automatic test_call_ret();
      to_exec();
      op_jump = 1'b1;
      jump_addr = 8'h10;
      #1;
      checks++;
      if (stb !== 5'b00100 || pc_in1 !== 8'h10) begin
         failures++;
         $display("FAIL jump strobes=%b in1=%h required 00100/10", stb, pc_in1);
      end
      clear_ops();
      to_exec();
      op_call = 1'b1;
      jump_addr = 8'h40;
      #1;
      checks++;
      if (pc !== 8'h10 || stb !== 5'b00100 || pc_in1 !== 8'h40) begin
         failures++;
         $display("FAIL call pc=%h strobes=%b in1=%h required 10/00100/40", pc, stb, pc_in1);
      end
      clear_ops();
      to_exec();
      op_ret = 1'b1;
      #1;
      checks++;
      if (pc !== 8'h40 || stb !== 5'b00001 || pc_dbus !== 8'h11) begin
         failures++;
         $display("FAIL ret pc=%h strobes=%b dbus=%h required 40/00001/11", pc, stb, pc_dbus);
      end
      clear_ops();
      to_exec();
      checks++;
      if (pc !== 8'h11 || stack_err !== 1'b0) begin
         failures++;
         $display("FAIL ret_target pc=%h err=%b required 11/0", pc, stack_err);
      end
   endtask
   task automatic test_branch();
      op_branch = 1'b1;
      branch_taken = 1'b1;
      branch_addr = 8'h22;
      #1;
      checks++;
      if (stb !== 5'b00010 || pc_in2 !== 8'h22) begin
         failures++;
         $display("FAIL branch_taken strobes=%b in2=%h required 00010/22", stb, pc_in2);
      end
      clear_ops();
      to_exec();
      op_branch = 1'b1;
      branch_addr = 8'h55;
      #1;
      checks++;
      if (pc !== 8'h22 || stb !== 5'b01000) begin
         failures++;
         $display("FAIL branch_not_taken pc=%h strobes=%b required 22/01000", pc, stb);
      end
      clear_ops();
      to_exec();
      checks++;
      if (pc !== 8'h23) begin
         failures++;
         $display("FAIL branch_fallthrough pc=%h required 23", pc);
      end
   endtask
   task automatic test_irq_wrap();
      op_jump = 1'b1;
      jump_addr = 8'hFF;
      clear_ops();
      to_exec();
      irq = 1'b1;
      op_jump = 1'b1;
      jump_addr = 8'h33;
      #1;
      checks++;
      if (pc !== 8'hFF || stb !== 5'b00001 || pc_dbus !== 8'hF0 || irq_ack !== 1'b1) begin
         failures++;
         $display("FAIL irq_entry pc=%h strobes=%b dbus=%h ack=%b required FF/00001/F0/1", pc, stb, pc_dbus, irq_ack);
      end
      clear_ops();
      to_exec();
      op_ret = 1'b1;
      #1;
      checks++;
      if (pc !== 8'hF0 || stb !== 5'b00001 || pc_dbus !== 8'h00 || irq_ack !== 1'b0) begin
         failures++;
         $display("FAIL irq_wrap_ret pc=%h strobes=%b dbus=%h ack=%b required F0/00001/00/0", pc, stb, pc_dbus, irq_ack);
      end
      clear_ops();
   endtask
   task automatic test_overflow();
      for (int i = 0; i < 5; i++) begin
         to_exec();
         op_call = 1'b1;
         jump_addr = 8'h60 + 8'(i * 16);
         #1;
         checks++;
         if (pc !== call_pc[i] || stb !== 5'b00100 || stack_err !== 1'b0) begin
            failures++;
            $display("FAIL call%0d pc=%h strobes=%b err=%b required %h/00100/0", i, pc, stb, stack_err, call_pc[i]);
         end
         clear_ops();
      end
      checks++;
      if (stack_err !== 1'b1 || pc !== 8'hA0) begin
         failures++;
         $display("FAIL overflow err=%b pc=%h required 1/A0", stack_err, pc);
      end
      for (int i = 0; i < 4; i++) begin
         to_exec();
         op_ret = 1'b1;
         #1;
         checks++;
         if (stb !== 5'b00001 || pc_dbus !== ret_exp[i]) begin
            failures++;
            $display("FAIL pop%0d strobes=%b dbus=%h required 00001/%h", i, stb, pc_dbus, ret_exp[i]);
         end
         clear_ops();
      end
      to_exec();
      op_ret = 1'b1;
      #1;
      checks++;
      if (pc !== 8'h01 || stb !== 5'b01000) begin
         failures++;
         $display("FAIL underflow_ret pc=%h strobes=%b required 01/01000", pc, stb);
      end
      clear_ops();
   endtask
   task automatic test_halt();
      to_exec();
      op_halt = 1'b1;
      #1;
      checks++;
      if (pc !== 8'h02 || stb !== 5'b00000) begin
         failures++;
         $display("FAIL halt_exec pc=%h strobes=%b required 02/00000", pc, stb);
      end
      clear_ops();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checks++;
         if (halted !== 1'b1 || stb !== 5'b00000 || fetch_req !== 1'b0 || pc !== 8'h02) begin
            failures++;
            $display("FAIL halt_cycle%0d halted=%b strobes=%b req=%b pc=%h required 1/00000/0/02", i, halted, stb, fetch_req, pc);
         end
      end
      irq = 1'b1;
      #1;
      checks++;
      if (stb !== 5'b00001 || pc_dbus !== 8'hF0 || irq_ack !== 1'b1) begin
         failures++;
         $display("FAIL halt_irq strobes=%b dbus=%h ack=%b required 00001/F0/1", stb, pc_dbus, irq_ack);
      end
      clear_ops();
      @(negedge clk);
      checks++;
      if (halted !== 1'b0 || fetch_req !== 1'b1 || pc !== 8'hF0) begin
         failures++;
         $display("FAIL halt_wake halted=%b req=%b pc=%h required 0/1/F0", halted, fetch_req, pc);
      end
      to_exec();
      op_ret = 1'b1;
      #1;
      checks++;
      if (stb !== 5'b00001 || pc_dbus !== 8'h03) begin
         failures++;
         $display("FAIL halt_ret strobes=%b dbus=%h required 00001/03", stb, pc_dbus);
      end
      clear_ops();
   endtask
   task automatic test_restart();
      to_exec();
      op_call = 1'b1;
      jump_addr = 8'h30;
      mem_ready = 1'b0;
      clear_ops();
      repeat (2) @(negedge clk);
      checks++;
      if (fetch_req !== 1'b1 || pc !== 8'h30 || stack_err !== 1'b1) begin
         failures++;
         $display("FAIL stall_fetch req=%b pc=%h err=%b required 1/30/1", fetch_req, pc, stack_err);
      end
      restart = 1'b1;
      #1;
      checks++;
      if (stb !== 5'b00000) begin
         failures++;
         $display("FAIL restart_fetch strobes=%b required 00000", stb);
      end
      clear_ops();
      mem_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (stb !== 5'b10000 || stack_err !== 1'b0) begin
         failures++;
         $display("FAIL restart_clear strobes=%b err=%b required 10000/0", stb, stack_err);
      end
      to_exec();
      op_ret = 1'b1;
      #1;
      checks++;
      if (pc !== 8'h00 || stb !== 5'b01000) begin
         failures++;
         $display("FAIL restart_flush pc=%h strobes=%b required 00/01000", pc, stb);
      end
      clear_ops();
   endtask
   task automatic test_async_reset();
      to_exec();
      mem_ready = 1'b0;
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (stb !== 5'b10000 || fetch_req !== 1'b0 || stack_err !== 1'b0) begin
         failures++;
         $display("FAIL async_reset strobes=%b req=%b err=%b required 10000/0/0", stb, fetch_req, stack_err);
      end
      @(negedge clk);
      rst_n = 1'b1;
      mem_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (fetch_req !== 1'b1 || pc !== 8'h00) begin
         failures++;
         $display("FAIL async_recover req=%b pc=%h required 1/00", fetch_req, pc);
      end
   endtask
   initial begin
      test_reset();
      test_call_ret();
      test_branch();
      test_irq_wrap();
      test_overflow();
      test_halt();
      test_restart();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
